// File: rtl/axil_uart_pkg.sv
// Shared definitions for the AXI-Lite UART transmit scheduler: register map,
// response codes and controller state encoding.
package axil_uart_pkg;

  localparam logic [31:0] REG_SETUP  = 32'h0;
  localparam logic [31:0] REG_FIFO   = 32'h4;
  localparam logic [31:0] REG_RXDATA = 32'h8;
  localparam logic [31:0] REG_TXDATA = 32'hC;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {
    ST_CFG_WR  = 3'd0,
    ST_CFG_B   = 3'd1,
    ST_IDLE    = 3'd2,
    ST_POLL_AR = 3'd3,
    ST_POLL_R  = 3'd4,
    ST_TX_WR   = 3'd5,
    ST_TX_B    = 3'd6
  } state_e;

endpackage

// File: rtl/axil_uart_tx_sched_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first asserted request at or
// after the pointer, wrapping modulo N_REQ. The pointer must be below N_REQ.
module rr_arbiter #(
  parameter int N_REQ = 2,
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [IDX_W-1:0] grant_o,
  output logic             any_o
);

  logic [IDX_W:0] idx;

  always_comb begin
    grant_o = '0;
    any_o   = 1'b0;
    idx     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = {1'b0, ptr_i} + (IDX_W + 1)'(k);
      if (idx >= (IDX_W + 1)'(N_REQ)) begin
        idx = idx - (IDX_W + 1)'(N_REQ);
      end
      if (!any_o && req_i[idx[IDX_W-1:0]]) begin
        any_o   = 1'b1;
        grant_o = idx[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/axil_uart_tx_sched.sv
// AXI-Lite master that programs the UART setup register once after reset and
// then funnels bytes from N_REQ requesters into the UART TX FIFO, one at a time.
module axil_uart_tx_sched
  import axil_uart_pkg::*;
#(
  parameter int          N_REQ          = 2,
  parameter int          AXI_ADDR_WIDTH = 32,
  parameter logic [31:0] UART_BASE      = 32'h0,
  parameter logic [31:0] SETUP_VAL      = 32'd868,
  parameter int          TXRDY_BIT      = 16,
  parameter logic [31:0] TXDATA_OFS     = REG_TXDATA
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [N_REQ-1:0]          req_valid_i,
  input  logic [N_REQ*8-1:0]        req_data_i,
  output logic [N_REQ-1:0]          req_ready_o,
  output logic                      cfg_done_o,
  output logic                      err_o,
  output logic                      m_awvalid_o,
  input  logic                      m_awready_i,
  output logic [AXI_ADDR_WIDTH-1:0] m_awaddr_o,
  output logic [2:0]                m_awprot_o,
  output logic                      m_wvalid_o,
  input  logic                      m_wready_i,
  output logic [31:0]               m_wdata_o,
  output logic [3:0]                m_wstrb_o,
  input  logic                      m_bvalid_i,
  output logic                      m_bready_o,
  input  logic [1:0]                m_bresp_i,
  output logic                      m_arvalid_o,
  input  logic                      m_arready_i,
  output logic [AXI_ADDR_WIDTH-1:0] m_araddr_o,
  output logic [2:0]                m_arprot_o,
  input  logic                      m_rvalid_i,
  output logic                      m_rready_o,
  input  logic [31:0]               m_rdata_i,
  input  logic [1:0]                m_rresp_i
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_SETUP  = AXI_ADDR_WIDTH'(UART_BASE + REG_SETUP);
  localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_FIFO   = AXI_ADDR_WIDTH'(UART_BASE + REG_FIFO);
  localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_TXDATA = AXI_ADDR_WIDTH'(UART_BASE + TXDATA_OFS);

  state_e                    state_q, state_d;
  logic                      awvalid_q, awvalid_d, wvalid_q, wvalid_d;
  logic                      aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic                      bready_q, bready_d, arvalid_q, arvalid_d, rready_q, rready_d;
  logic [AXI_ADDR_WIDTH-1:0] awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic [31:0]               wdata_q, wdata_d;
  logic [IDX_W-1:0]          grant_q, grant_d, ptr_q, ptr_d;
  logic [7:0]                byte_q, byte_d;
  logic [N_REQ-1:0]          req_ready_q, req_ready_d;
  logic                      cfg_done_q, cfg_done_d, err_q, err_d;

  logic [IDX_W-1:0] arb_idx;
  logic             arb_any;
  logic             aw_fire, w_fire, b_fire, ar_fire, r_fire, is_cfg;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req_i   (req_valid_i),
    .ptr_i   (ptr_q),
    .grant_o (arb_idx),
    .any_o   (arb_any)
  );

  assign aw_fire = awvalid_q & m_awready_i;
  assign w_fire  = wvalid_q & m_wready_i;
  assign b_fire  = bready_q & m_bvalid_i;
  assign ar_fire = arvalid_q & m_arready_i;
  assign r_fire  = rready_q & m_rvalid_i;
  assign is_cfg  = (state_q == ST_CFG_WR) || (state_q == ST_CFG_B);

  always_comb begin
    state_d     = state_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    awaddr_d    = awaddr_q;
    araddr_d    = araddr_q;
    wdata_d     = wdata_q;
    grant_d     = grant_q;
    ptr_d       = ptr_q;
    byte_d      = byte_q;
    req_ready_d = '0;
    cfg_done_d  = cfg_done_q;
    err_d       = err_q;

    // Error responses are only recorded; the sequence carries on regardless.
    if ((b_fire && (m_bresp_i != RESP_OKAY)) || (r_fire && (m_rresp_i != RESP_OKAY))) begin
      err_d = 1'b1;
    end

    case (state_q)
      ST_CFG_WR, ST_TX_WR: begin
        // AW and W are launched together but each retires on its own ready.
        if (!awvalid_q && !aw_done_q) begin
          awvalid_d = 1'b1;
          awaddr_d  = is_cfg ? ADDR_SETUP : ADDR_TXDATA;
        end
        if (!wvalid_q && !w_done_q) begin
          wvalid_d = 1'b1;
          wdata_d  = is_cfg ? SETUP_VAL : {24'b0, byte_q};
        end
        if (aw_fire) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_fire) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if ((aw_done_q || aw_fire) && (w_done_q || w_fire)) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          bready_d  = 1'b1;
          state_d   = is_cfg ? ST_CFG_B : ST_TX_B;
        end
      end
      ST_CFG_B, ST_TX_B: begin
        if (b_fire) begin
          bready_d = 1'b0;
          state_d  = ST_IDLE;
          if (is_cfg) begin
            cfg_done_d = 1'b1;
          end else begin
            req_ready_d[grant_q] = 1'b1;
            ptr_d = (grant_q == IDX_W'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
          end
        end
      end
      ST_IDLE: begin
        if (arb_any) begin
          grant_d   = arb_idx;
          byte_d    = req_data_i[{arb_idx, 3'b000} +: 8];
          arvalid_d = 1'b1;
          araddr_d  = ADDR_FIFO;
          state_d   = ST_POLL_AR;
        end
      end
      ST_POLL_AR: begin
        if (ar_fire) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_POLL_R;
        end
      end
      ST_POLL_R: begin
        if (r_fire) begin
          rready_d = 1'b0;
          if (m_rdata_i[TXRDY_BIT]) begin
            state_d = ST_TX_WR;
          end else begin
            arvalid_d = 1'b1;
            state_d   = ST_POLL_AR;
          end
        end
      end
      default: state_d = ST_CFG_WR;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_CFG_WR;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      awaddr_q    <= '0;
      araddr_q    <= '0;
      wdata_q     <= '0;
      grant_q     <= '0;
      ptr_q       <= '0;
      byte_q      <= '0;
      req_ready_q <= '0;
      cfg_done_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      awaddr_q    <= awaddr_d;
      araddr_q    <= araddr_d;
      wdata_q     <= wdata_d;
      grant_q     <= grant_d;
      ptr_q       <= ptr_d;
      byte_q      <= byte_d;
      req_ready_q <= req_ready_d;
      cfg_done_q  <= cfg_done_d;
      err_q       <= err_d;
    end
  end

  assign req_ready_o = req_ready_q;
  assign cfg_done_o  = cfg_done_q;
  assign err_o       = err_q;
  assign m_awvalid_o = awvalid_q;
  assign m_awaddr_o  = awaddr_q;
  assign m_awprot_o  = 3'b000;
  assign m_wvalid_o  = wvalid_q;
  assign m_wdata_o   = wdata_q;
  assign m_wstrb_o   = 4'hF;
  assign m_bready_o  = bready_q;
  assign m_arvalid_o = arvalid_q;
  assign m_araddr_o  = araddr_q;
  assign m_arprot_o  = 3'b000;
  assign m_rready_o  = rready_q;

endmodule

// File: tb/tb_axil_uart_tx_sched.sv
// Bench for axil_uart_tx_sched: an AXI-Lite UART slave and requester agent run
// on the falling edge; directed steps with random bytes are scored against a
// round-robin reference model.
module tb_axil_uart_tx_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_valid;
  logic [15:0] req_data;
  logic [1:0]  m_req_ready;
  logic        m_cfg_done, m_err;
  logic        m_awvalid, awready, m_wvalid, wready, bvalid, m_bready;
  logic        m_arvalid, arready, rvalid, m_rready;
  logic [31:0] m_awaddr, m_araddr, m_wdata, rdata;
  logic [2:0]  m_awprot, m_arprot;
  logic [3:0]  m_wstrb;
  logic [1:0]  bresp, rresp;

  axil_uart_tx_sched #(.N_REQ(2)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_data_i(req_data), .req_ready_o(m_req_ready),
    .cfg_done_o(m_cfg_done), .err_o(m_err),
    .m_awvalid_o(m_awvalid), .m_awready_i(awready), .m_awaddr_o(m_awaddr), .m_awprot_o(m_awprot),
    .m_wvalid_o(m_wvalid), .m_wready_i(wready), .m_wdata_o(m_wdata), .m_wstrb_o(m_wstrb),
    .m_bvalid_i(bvalid), .m_bready_o(m_bready), .m_bresp_i(bresp),
    .m_arvalid_o(m_arvalid), .m_arready_i(arready), .m_araddr_o(m_araddr), .m_arprot_o(m_arprot),
    .m_rvalid_i(rvalid), .m_rready_o(m_rready), .m_rdata_i(rdata), .m_rresp_i(rresp)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int n_chk = 0, n_pass = 0;
  // slave / agent state
  logic        s_awvalid, s_wvalid, s_arvalid, s_rready, s_bready;
  logic [31:0] s_awaddr, s_wdata, s_araddr, cur_aw, cur_w, ar_addr_last;
  bit          aw_got, w_got, wdelay, agent_drive;
  int          wcnt, stall_polls, err_wr_idx, wr_cnt, ar_cnt;
  int          viol_overlap, viol_ar_pre_cfg, viol_pulse;
  int          aw_fire_edge, w_fire_edge, first_aw_rel, rel_edge, grant_edge, pulse_edge;
  logic [31:0] wr_addr[$], wr_data[$];
  int          acc_idx[$];
  logic [7:0]  rq0[$], rq1[$];
  // reference model state
  logic [7:0]  mq0[$], mq1[$], exp_byte[$];
  int          exp_idx[$];
  int          model_ptr;

  always @(negedge clk) begin
    if (!rst_n) begin
      awready = 0; wready = 0; bvalid = 0; bresp = 0; arready = 0;
      rvalid = 0; rdata = 0; rresp = 0; aw_got = 0; w_got = 0; wcnt = 0;
      s_awvalid = 0; s_wvalid = 0; s_arvalid = 0; s_rready = 0; s_bready = 0;
      s_awaddr = 0; s_wdata = 0; s_araddr = 0;
    end else begin
      if (s_awvalid && awready) begin
        aw_got = 1; cur_aw = s_awaddr; aw_fire_edge = edge_cnt;
        if (wdelay) wcnt = 1;
      end
      if (s_wvalid && wready) begin
        w_got = 1; cur_w = s_wdata; w_fire_edge = edge_cnt;
      end
      if (s_bready && bvalid) bvalid = 0;
      if (s_rready && rvalid) rvalid = 0;
      if (s_arvalid && arready) begin
        ar_cnt++; ar_addr_last = s_araddr; rvalid = 1; rresp = 2'b00;
        if (stall_polls > 0) begin
          rdata = $urandom & ~32'h0001_0000; stall_polls--;
        end else begin
          rdata = $urandom | 32'h0001_0000;
        end
      end
      if (aw_got && w_got) begin
        wr_addr.push_back(cur_aw); wr_data.push_back(cur_w);
        bvalid = 1; bresp = (wr_cnt == err_wr_idx) ? 2'b10 : 2'b00;
        wr_cnt++; aw_got = 0; w_got = 0;
      end
      awready = 1; arready = 1;
      wready  = wdelay ? (aw_got && wcnt == 0) : 1'b1;
      if (wcnt > 0) wcnt--;
      if (m_arvalid && (m_awvalid || m_wvalid || aw_got || w_got || bvalid)) viol_overlap++;
      if ((m_awvalid || m_wvalid) && (rvalid || m_rready)) viol_overlap++;
      if (m_arvalid && !m_cfg_done) viol_ar_pre_cfg++;
      if (m_awvalid && first_aw_rel < 0) first_aw_rel = edge_cnt - rel_edge;
      if (m_arvalid && !s_arvalid) grant_edge = edge_cnt;
      s_awvalid = m_awvalid; s_wvalid = m_wvalid; s_arvalid = m_arvalid;
      s_rready = m_rready; s_bready = m_bready;
      s_awaddr = m_awaddr; s_wdata = m_wdata; s_araddr = m_araddr;
    end
    if (m_req_ready != 2'b00) begin
      if ($countones(m_req_ready) != 1) viol_pulse++;
      pulse_edge = edge_cnt;
      for (int i = 0; i < 2; i++) begin
        if (m_req_ready[i]) begin
          acc_idx.push_back(i);
          if (agent_drive && i == 0 && rq0.size() > 0) void'(rq0.pop_front());
          if (agent_drive && i == 1 && rq1.size() > 0) void'(rq1.pop_front());
        end
      end
    end
    if (agent_drive) begin
      req_valid[0]   = rq0.size() > 0;
      req_data[7:0]  = (rq0.size() > 0) ? rq0[0] : 8'h00;
      req_valid[1]   = rq1.size() > 0;
      req_data[15:8] = (rq1.size() > 0) ? rq1[0] : 8'h00;
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Round-robin over whatever bytes are queued, all requesters held valid.
  task automatic model_run();
    int p, pick;
    p = model_ptr;
    while (mq0.size() + mq1.size() > 0) begin
      pick = -1;
      for (int k = 0; k < 2; k++) begin
        if (pick < 0 && ((((p + k) % 2) == 0) ? mq0.size() : mq1.size()) > 0) pick = (p + k) % 2;
      end
      exp_idx.push_back(pick);
      exp_byte.push_back((pick == 0) ? mq0.pop_front() : mq1.pop_front());
      p = (pick + 1) % 2;
    end
    model_ptr = p;
  endtask

  task automatic wait_acc(input int n, input int budget);
    int c = 0;
    while (acc_idx.size() < n && c < budget) begin tick(); c++; end
    check("wait_accept_timeout", 32'(acc_idx.size() >= n), 32'd1);
  endtask

  task automatic wait_cfg(input int budget);
    int c = 0;
    while (!m_cfg_done && c < budget) begin tick(); c++; end
    check("wait_cfg_timeout", 32'(m_cfg_done), 32'd1);
  endtask

  task automatic compare_stream(input string tag);
    logic [31:0] d, a;
    int ix;
    check({tag, "_count"}, wr_data.size(), exp_byte.size());
    check({tag, "_accepts"}, acc_idx.size(), exp_idx.size());
    for (int i = 0; i < exp_byte.size(); i++) begin
      d  = (i < wr_data.size()) ? wr_data[i] : 32'hDEAD_BEEF;
      a  = (i < wr_addr.size()) ? wr_addr[i] : 32'hDEAD_BEEF;
      ix = (i < acc_idx.size()) ? acc_idx[i] : -1;
      check({tag, "_wdata"}, d, {24'b0, exp_byte[i]});
      check({tag, "_awaddr"}, a, 32'hC);
      check({tag, "_grant"}, ix, exp_idx[i]);
    end
    exp_byte.delete(); exp_idx.delete();
    wr_data.delete(); wr_addr.delete(); acc_idx.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_awvalid"}, 32'(m_awvalid), 0);
    check({tag, "_wvalid"}, 32'(m_wvalid), 0);
    check({tag, "_arvalid"}, 32'(m_arvalid), 0);
    check({tag, "_bready"}, 32'(m_bready), 0);
    check({tag, "_rready"}, 32'(m_rready), 0);
    check({tag, "_req_ready"}, 32'(m_req_ready), 0);
    check({tag, "_cfg_done"}, 32'(m_cfg_done), 0);
    check({tag, "_err"}, 32'(m_err), 0);
    check({tag, "_awaddr"}, m_awaddr, 0);
    check({tag, "_araddr"}, m_araddr, 0);
    check({tag, "_wdata"}, m_wdata, 0);
    check({tag, "_wstrb"}, 32'(m_wstrb), 32'hF);
    check({tag, "_prot"}, 32'({m_awprot, m_arprot}), 0);
  endtask

  initial begin
    logic [7:0] b;
    int ar0, n0, n1, c;
    req_valid = 0; req_data = 0; agent_drive = 1; wdelay = 0; stall_polls = 0;
    err_wr_idx = -1; wr_cnt = 0; ar_cnt = 0; viol_overlap = 0; viol_ar_pre_cfg = 0;
    viol_pulse = 0; first_aw_rel = -1; rel_edge = 0; model_ptr = 0;
    grant_edge = 0; pulse_edge = 0; aw_fire_edge = 0; w_fire_edge = 0;
    repeat (3) tick();
    check_reset_outputs("rst");

    // configuration write after release
    tick(); rel_edge = edge_cnt; rst_n = 1;
    wait_cfg(50);
    check("cfg_first_aw_cycle", first_aw_rel, 1);
    check("cfg_writes", wr_addr.size(), 1);
    check("cfg_addr", wr_addr.size() > 0 ? wr_addr[0] : 32'hDEAD_BEEF, 32'h0);
    check("cfg_data", wr_data.size() > 0 ? wr_data[0] : 32'hDEAD_BEEF, 32'd868);
    check("cfg_no_ar", ar_cnt, 0);
    wr_addr.delete(); wr_data.delete();

    // single byte from requester 0
    ar0 = ar_cnt;
    rq0.push_back(8'h41); mq0.push_back(8'h41); model_run();
    wait_acc(1, 100);
    repeat (4) tick();
    check("single_ar_count", ar_cnt - ar0, 1);
    check("single_ar_addr", ar_addr_last, 32'h4);
    check("single_latency", pulse_edge - grant_edge, 5);
    compare_stream("single");

    // both requesters continuously valid
    rq0.push_back(8'h11); rq0.push_back(8'h11); mq0.push_back(8'h11); mq0.push_back(8'h11);
    rq1.push_back(8'h22); rq1.push_back(8'h22); mq1.push_back(8'h22); mq1.push_back(8'h22);
    model_run();
    wait_acc(4, 200);
    compare_stream("alt");

    // TX FIFO full for three polls
    ar0 = ar_cnt; stall_polls = 3; b = 8'($urandom);
    rq1.push_back(b); mq1.push_back(b); model_run();
    wait_acc(1, 200);
    check("stall_ar_count", ar_cnt - ar0, 4);
    compare_stream("stall");

    // randomized streams
    for (int r = 0; r < 3; r++) begin
      n0 = $urandom_range(0, 4); n1 = $urandom_range(1, 4);
      stall_polls = $urandom_range(0, 2);
      for (int k = 0; k < n0; k++) begin b = 8'($urandom); rq0.push_back(b); mq0.push_back(b); end
      for (int k = 0; k < n1; k++) begin b = 8'($urandom); rq1.push_back(b); mq1.push_back(b); end
      model_run();
      wait_acc(n0 + n1, 60 * (n0 + n1) + 50);
      compare_stream("rand");
    end

    // delayed W channel and a SLVERR write response
    check("err_before", 32'(m_err), 0);
    wdelay = 1; err_wr_idx = wr_cnt;
    b = 8'($urandom); rq0.push_back(b); mq0.push_back(b);
    b = 8'($urandom); rq1.push_back(b); mq1.push_back(b);
    model_run();
    wait_acc(2, 200);
    check("wdelay_split", w_fire_edge - aw_fire_edge, 2);
    compare_stream("slverr");
    wdelay = 0; err_wr_idx = -1;
    repeat (3) tick();
    check("err_sticky", 32'(m_err), 1);

    // byte latched at grant; requester changes data and drops valid afterwards
    agent_drive = 0; req_valid = 2'b01; req_data = 16'h005A;
    c = 0;
    while (!m_arvalid && c < 50) begin tick(); c++; end
    check("latch_grant_seen", 32'(m_arvalid), 1);
    req_data = 16'h00A5; req_valid = 2'b00;
    mq0.push_back(8'h5A); model_run();
    wait_acc(1, 100);
    compare_stream("latch");
    agent_drive = 1;

    // reset while waiting for B of a TX write
    b = 8'($urandom); rq0.push_back(b);
    c = 0;
    while (!m_bready && c < 100) begin tick(); c++; end
    check("txb_reached", 32'(m_bready), 1);
    rst_n = 0; #1;
    check_reset_outputs("midrst");
    repeat (2) tick();
    wr_addr.delete(); wr_data.delete(); acc_idx.delete();
    first_aw_rel = -1; model_ptr = 0;
    rel_edge = edge_cnt; rst_n = 1;
    mq0.push_back(b); model_run();
    wait_cfg(50);
    check("rerun_first_aw_cycle", first_aw_rel, 1);
    check("rerun_cfg_addr", wr_addr.size() > 0 ? wr_addr[0] : 32'hDEAD_BEEF, 32'h0);
    check("rerun_cfg_data", wr_data.size() > 0 ? wr_data[0] : 32'hDEAD_BEEF, 32'd868);
    if (wr_addr.size() > 0) begin void'(wr_addr.pop_front()); void'(wr_data.pop_front()); end
    wait_acc(1, 100);
    compare_stream("rerun");

    check("viol_overlap", viol_overlap, 0);
    check("viol_ar_before_cfg", viol_ar_pre_cfg, 0);
    check("viol_pulse", viol_pulse, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
